csi2_raw8_depacketizer: RTL and testbench

- Sits directly upstream of the SDRAM arbiter, in the mipi_clk domain. Input is 4-lane-aligned CSI-2 words from the lane aligner.
- Parses CSI-2 packet headers and tracks frame boundaries.
- Forwards only RAW8 payload words belonging to a complete frame as mipi_data_enable / mipi_data[3:0].
- Buffers each line and drains it at most one word every two cycles, because the arbiter splits each 4-byte word into two 16-bit FIFO writes.

---
 rtl/csi2_raw8_depacketizer.sv | 179 +++++++++++++++++
 tb/tb_csi2_raw8_depacketizer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_raw8_depacketizer.sv
// CSI-2 RAW8 depacketizer: parses packet headers, tracks frame boundaries and
// buffers forwarded payload, draining at most one word every two cycles.
module csi2_raw8_depacketizer #(
    parameter int         FIFO_POINTER_WIDTH = 7,
    parameter logic [7:0] DATA_TYPE          = 8'h2A,
    parameter logic [1:0] VIRTUAL_CHANNEL    = 2'd0,
    parameter int         LINE_COUNT_WIDTH   = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic                        in_start,
    input  logic [3:0][7:0]             in_data,
    output logic                        mipi_data_enable,
    output logic [3:0][7:0]             mipi_data,
    output logic                        frame_start,
    output logic                        frame_end,
    output logic [LINE_COUNT_WIDTH-1:0] line_count,
    output logic                        overflow,
    output logic                        packet_error
);

    localparam int DEPTH = 1 << FIFO_POINTER_WIDTH;
    localparam logic [FIFO_POINTER_WIDTH:0] FULL = (FIFO_POINTER_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CRC
    } state_t;

    state_t                      state;
    logic                        in_frame;
    logic                        fwd;
    logic [14:0]                 words_left;
    logic [1:0]                  tail_bytes;

    logic [31:0]                 mem [DEPTH];
    logic [FIFO_POINTER_WIDTH-1:0] wr_ptr;
    logic [FIFO_POINTER_WIDTH-1:0] rd_ptr;
    logic [FIFO_POINTER_WIDTH:0]   count;
    logic                        cooldown;

    logic                        header;
    logic [7:0]                  di;
    logic [15:0]                 wc;
    logic [5:0]                  dt;
    logic [1:0]                  vc;
    logic                        vc_match;
    logic                        is_short;
    logic                        hdr_fwd;
    logic [14:0]                 wc_words;
    logic                        payload_word;
    logic                        last_word;
    logic [3:0][7:0]             push_data;
    logic                        push;
    logic                        full;
    logic                        pop;
    logic                        write;

    always_comb begin
        header       = in_valid & in_start;
        di           = in_data[0];
        wc           = {in_data[2], in_data[1]};
        dt           = di[5:0];
        vc           = di[7:6];
        vc_match     = (vc == VIRTUAL_CHANNEL);
        is_short     = (dt < 6'h10);
        hdr_fwd      = ({2'b00, dt} == DATA_TYPE) && vc_match && in_frame;
        wc_words     = {1'b0, wc[15:2]} + {14'd0, |wc[1:0]};
        payload_word = in_valid & ~in_start & (state == PAYLOAD);
        last_word    = payload_word & (words_left == 15'd1);
        push_data    = in_data;
        // Bytes past the word count in a trailing partial word are zeroed.
        if (last_word && tail_bytes != 2'd0) begin
            for (int i = 1; i < 4; i++) begin
                if (i >= int'(tail_bytes)) begin
                    push_data[i] = 8'h00;
                end
            end
        end
        push  = payload_word & fwd;
        full  = (count == FULL);
        pop   = (count != '0) & ~cooldown;
        write = push & ~full;
    end

    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            cooldown         <= 1'b0;
            mipi_data_enable <= 1'b0;
            mipi_data        <= '0;
            overflow         <= 1'b0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                mipi_data <= mem[rd_ptr];
            end
            count <= count + (FIFO_POINTER_WIDTH + 1)'(write)
                           - (FIFO_POINTER_WIDTH + 1)'(pop);
            mipi_data_enable <= pop;
            cooldown         <= pop;
            if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            in_frame     <= 1'b0;
            fwd          <= 1'b0;
            words_left   <= '0;
            tail_bytes   <= '0;
            line_count   <= '0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            packet_error <= 1'b0;
        end else begin
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            packet_error <= 1'b0;
            if (header) begin
                // A header inside a packet truncates it; the line is not counted.
                if (state != IDLE) begin
                    packet_error <= 1'b1;
                end
                if (is_short) begin
                    state <= IDLE;
                    if (vc_match && dt == 6'h00) begin
                        frame_start <= 1'b1;
                        in_frame    <= 1'b1;
                        line_count  <= '0;
                    end
                    if (vc_match && dt == 6'h01) begin
                        frame_end <= 1'b1;
                        in_frame  <= 1'b0;
                    end
                end else begin
                    fwd        <= hdr_fwd;
                    words_left <= wc_words;
                    tail_bytes <= wc[1:0];
                    state      <= (wc == 16'd0) ? CRC : PAYLOAD;
                    if (hdr_fwd && wc[1:0] != 2'b00) begin
                        packet_error <= 1'b1;
                    end
                end
            end else if (in_valid) begin
                case (state)
                    PAYLOAD: begin
                        words_left <= words_left - 15'd1;
                        if (last_word) begin
                            state <= CRC;
                            if (fwd) begin
                                line_count <= line_count + LINE_COUNT_WIDTH'(1);
                            end
                        end
                    end
                    CRC: state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csi2_raw8_depacketizer.sv
// Bench for csi2_raw8_depacketizer: table of packet cases, hand-written
// corner sequences and a random packet stream against a packet-level model.
module tb_csi2_raw8_depacketizer;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_start = 1'b0;
    logic [3:0][7:0] in_data = '0;
    logic            mipi_data_enable;
    logic [3:0][7:0] mipi_data;
    logic            frame_start;
    logic            frame_end;
    logic [11:0]     line_count;
    logic            overflow;
    logic            packet_error;

    csi2_raw8_depacketizer dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_start         (in_start),
        .in_data          (in_data),
        .mipi_data_enable (mipi_data_enable),
        .mipi_data        (mipi_data),
        .frame_start      (frame_start),
        .frame_end        (frame_end),
        .line_count       (line_count),
        .overflow         (overflow),
        .packet_error     (packet_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    logic [31:0] got[$];
    int          got_cyc[$];
    int          fs_cnt = 0;
    int          fe_cnt = 0;
    int          perr_cnt = 0;
    logic        prev_en = 1'b0;
    logic        double_en = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_en <= 1'b0;
        end else begin
            if (mipi_data_enable) begin
                got.push_back(mipi_data);
                got_cyc.push_back(cyc);
                if (prev_en) double_en <= 1'b1;
            end
            prev_en <= mipi_data_enable;
            if (frame_start) fs_cnt <= fs_cnt + 1;
            if (frame_end) fe_cnt <= fe_cnt + 1;
            if (packet_error) perr_cnt <= perr_cnt + 1;
        end
    end

    // Packet-level reference model
    bit          m_in_frame = 1'b0;
    logic [11:0] m_line = '0;
    int          m_fs = 0;
    int          m_fe = 0;
    int          m_perr = 0;
    logic [31:0] exp_q[$];
    int          got_rd = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [5:0] dt, input logic [1:0] vc,
                                        input logic [15:0] wc);
        return {8'h00, wc[15:8], wc[7:0], vc, dt};
    endfunction

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        @(posedge clk);
        #1;
        in_valid = v;
        in_start = s;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic send_short(input logic [5:0] dt, input logic [1:0] vc);
        drive(1'b1, 1'b1, hdr(dt, vc, 16'd0));
        if (vc == 2'd0 && dt == 6'h00) begin
            m_in_frame = 1'b1;
            m_line = '0;
            m_fs++;
        end else if (vc == 2'd0 && dt == 6'h01) begin
            m_in_frame = 1'b0;
            m_fe++;
        end
    endtask

    task automatic send_long(input logic [5:0] dt, input logic [1:0] vc,
                             input logic [15:0] wc, input bit gaps);
        int          nw;
        int          r;
        bit          f;
        logic [31:0] w;
        logic [31:0] mask;
        nw = (int'(wc) + 3) / 4;
        r  = int'(wc[1:0]);
        f  = (dt == 6'h2A) && (vc == 2'd0) && m_in_frame;
        if (f && r != 0) m_perr++;
        drive(1'b1, 1'b1, hdr(dt, vc, wc));
        for (int i = 0; i < nw; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            w = $urandom;
            drive(1'b1, 1'b0, w);
            if (f) begin
                mask = (i == nw - 1 && r != 0) ? (32'hFFFF_FFFF >> (8 * (4 - r)))
                                               : 32'hFFFF_FFFF;
                exp_q.push_back(w & mask);
            end
        end
        drive(1'b1, 1'b0, $urandom);
        if (f && nw > 0) m_line++;
    endtask

    task automatic settle_check(input string name, output int n_en);
        idle(300);
        n_en = got.size() - got_rd;
        chk({name, " enables"}, n_en, exp_q.size());
        for (int i = 0; i < exp_q.size() && got_rd + i < got.size(); i++)
            chk({name, " word"}, got[got_rd + i], exp_q[i]);
        got_rd = got.size();
        exp_q.delete();
        chk({name, " line_count"}, line_count, m_line);
        chk({name, " frame_start"}, fs_cnt, m_fs);
        chk({name, " frame_end"}, fe_cnt, m_fe);
        chk({name, " packet_error"}, perr_cnt, m_perr);
        chk({name, " overflow"}, overflow, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) begin
            in_valid = 1'($urandom);
            in_start = 1'($urandom);
            in_data  = $urandom;
            @(negedge clk);
            chk("reset outputs", {mipi_data_enable, frame_start, frame_end,
                                  packet_error, overflow, line_count, mipi_data}, 0);
            @(posedge clk);
            #1;
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        in_start = 1'b0;
        m_in_frame = 1'b0;
        m_line = '0;
        exp_q.delete();
        got_rd = got.size();
    endtask

    typedef struct {
        bit          pre_fs;
        logic [5:0]  dt;
        logic [1:0]  vc;
        logic [15:0] wc;
        int          en;
        int          line;
        int          perr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int          n;
        int          c0;
        int          base;
        int          p0;
        int          k;
        logic [1:0]  rvc;
        logic [5:0]  rdt;
        logic [31:0] first;

        tbl[0] = '{1'b1, 6'h2A, 2'd0, 16'd8,  2,  1, 0};
        tbl[1] = '{1'b1, 6'h2B, 2'd0, 16'd8,  0,  0, 0};
        tbl[2] = '{1'b1, 6'h2A, 2'd1, 16'd8,  0,  0, 0};
        tbl[3] = '{1'b1, 6'h2A, 2'd0, 16'd5,  2,  1, 1};
        tbl[4] = '{1'b1, 6'h2A, 2'd0, 16'd4,  1,  1, 0};
        tbl[5] = '{1'b1, 6'h2A, 2'd0, 16'd1,  1,  1, 1};
        tbl[6] = '{1'b0, 6'h2A, 2'd0, 16'd8,  0,  1, 0};
        tbl[7] = '{1'b1, 6'h12, 2'd0, 16'd12, 0,  0, 0};
        tbl[8] = '{1'b1, 6'h2A, 2'd0, 16'd64, 16, 1, 0};
        tbl[9] = '{1'b1, 6'h2A, 2'd2, 16'd4,  0,  0, 0};

        do_reset();

        // RAW8 line before any frame start is dropped
        send_long(6'h2A, 2'd0, 16'd8, 1'b0);
        settle_check("pre-fs", n);
        chk("pre-fs count", n, 0);

        // Basic frame with latency and spacing checks
        send_short(6'h00, 2'd0);
        drive(1'b1, 1'b1, hdr(6'h2A, 2'd0, 16'd8));
        drive(1'b1, 1'b0, 32'h0302_0100);
        c0 = cyc;
        drive(1'b1, 1'b0, 32'h0706_0504);
        drive(1'b1, 1'b0, $urandom);
        send_short(6'h01, 2'd0);
        exp_q.push_back(32'h0302_0100);
        exp_q.push_back(32'h0706_0504);
        m_line++;
        base = got_rd;
        settle_check("basic", n);
        if (got.size() >= base + 2) begin
            chk("basic latency", got_cyc[base] - c0, 2);
            chk("basic gap", (got_cyc[base + 1] - got_cyc[base]) >= 2, 1);
        end
        chk("basic hold", mipi_data, 32'h0706_0504);

        foreach (tbl[i]) begin
            p0 = perr_cnt;
            if (tbl[i].pre_fs) send_short(6'h00, 2'd0);
            else send_short(6'h01, 2'd0);
            send_long(tbl[i].dt, tbl[i].vc, tbl[i].wc, 1'b0);
            settle_check($sformatf("row%0d", i), n);
            chk($sformatf("row%0d en", i), n, tbl[i].en);
            chk($sformatf("row%0d line", i), line_count, tbl[i].line);
            chk($sformatf("row%0d perr", i), perr_cnt - p0, tbl[i].perr);
        end

        // Random packet stream
        send_short(6'h00, 2'd0);
        for (int p = 0; p < 25; p++) begin
            k   = $urandom_range(0, 9);
            rvc = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
            if ($urandom_range(0, 3) == 0) drive(1'b1, 1'b0, $urandom);
            if (k == 0) send_short(6'h00, rvc);
            else if (k == 1) send_short(6'h01, rvc);
            else begin
                case ($urandom_range(0, 4))
                    0: rdt = 6'h2B;
                    1: rdt = 6'h12;
                    default: rdt = 6'h2A;
                endcase
                send_long(rdt, rvc, 16'($urandom_range(1, 24)), 1'b1);
            end
            idle($urandom_range(0, 2));
        end
        settle_check("random", n);

        // Header arriving mid-payload truncates the first packet
        send_short(6'h00, 2'd0);
        drive(1'b1, 1'b1, hdr(6'h2A, 2'd0, 16'd32));
        for (int i = 0; i < 3; i++) begin
            first = $urandom;
            drive(1'b1, 1'b0, first);
            exp_q.push_back(first);
        end
        m_perr++;
        send_long(6'h2A, 2'd0, 16'd8, 1'b0);
        settle_check("interrupt", n);
        chk("interrupt count", n, 5);
        chk("interrupt line", line_count, 1);

        // 160-word line fits the buffer
        send_short(6'h00, 2'd0);
        send_long(6'h2A, 2'd0, 16'd640, 1'b0);
        settle_check("line160", n);
        chk("line160 count", n, 160);

        // 300-word line overflows
        send_short(6'h00, 2'd0);
        send_long(6'h2A, 2'd0, 16'd1200, 1'b0);
        idle(700);
        n = got.size() - got_rd;
        chk("ovf flag", overflow, 1);
        chk("ovf enables below 300", n < 300, 1);
        chk("ovf enables above depth", n > 128, 1);
        if (n > 0) chk("ovf first word", got[got_rd], exp_q[0]);
        chk("ovf line", line_count, m_line);
        idle(50);
        chk("ovf sticky", overflow, 1);
        exp_q.delete();
        got_rd = got.size();

        do_reset();
        chk("post-reset overflow", overflow, 0);

        // Reset in the middle of a packet; the tail is ignored afterwards
        send_short(6'h00, 2'd0);
        drive(1'b1, 1'b1, hdr(6'h2A, 2'd0, 16'd32));
        repeat (3) drive(1'b1, 1'b0, $urandom);
        do_reset();
        repeat (5) drive(1'b1, 1'b0, $urandom);
        drive(1'b1, 1'b0, $urandom);
        settle_check("mid-reset", n);
        chk("mid-reset count", n, 0);

        chk("no back-to-back enable", double_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
